// File: rtl/ss_thermo_capture_pkg.sv
// Shared types and constants for the flash-ADC thermometer capture block.
// Holds the FSM state encoding, converter geometry and the default settle time.
package ss_thermo_capture_pkg;

  localparam int unsigned ADC_BITS       = 3;
  localparam int unsigned THERM_W        = 2 ** ADC_BITS;
  localparam int unsigned N_CMP          = THERM_W - 1;
  localparam int unsigned SETTLE_CYC_DEF = 4;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ss_thermo_capture_bubble_fix.sv
// Combinational bubble suppression and thermometer enforcement for the
// synchronized comparator vector; output bit 0 is the constant-zero code slot.
module ss_bubble_fix
  import ss_thermo_capture_pkg::*;
(
  input  logic [N_CMP-1:0]   s_i,
  output logic [THERM_W-1:0] therm_o
);

  logic [N_CMP+1:0] ext;
  logic [N_CMP-1:0] bub;
  logic [N_CMP-1:0] therm;

  // Pad with the implied neighbours: below threshold 0 is always "above", above 6 never.
  assign ext = {1'b0, s_i, 1'b1};

  always_comb begin
    bub   = '0;
    therm = '0;
    for (int k = 0; k < int'(N_CMP); k++) begin
      bub[k] = maj3(ext[k], ext[k+1], ext[k+2]);
    end
    therm[0] = bub[0];
    for (int k = 1; k < int'(N_CMP); k++) begin
      therm[k] = therm[k-1] & bub[k];
    end
  end

  assign therm_o = {therm, 1'b0};

endmodule

// File: rtl/ss_thermo_capture.sv
// Captures asynchronous comparator outputs through a synchronizer, waits a
// settle interval after each conversion request and registers a cleaned code.
module ss_thermo_capture
  import ss_thermo_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CMP-1:0]   cmp_in,
  input  logic               conv_start,
  output logic               conv_busy,
  output logic [THERM_W-1:0] therm_out,
  output logic               therm_valid,
  output logic               err_overrun
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  logic [N_CMP-1:0]   sync_q [SYNC_STAGES];
  logic [N_CMP-1:0]   cmp_s;
  logic [THERM_W-1:0] fixed_code;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [THERM_W-1:0] therm_q, therm_d;
  logic               ovr_q, ovr_d;

  // Free-running synchronizer; every stage is reset so no X reaches the encoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= cmp_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign cmp_s = sync_q[SYNC_STAGES-1];

  ss_bubble_fix u_bubble_fix (
    .s_i     (cmp_s),
    .therm_o (fixed_code)
  );

  // NOTE: state flops use non-blocking assignments only; all decode lives in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      therm_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      therm_q <= therm_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    therm_d = therm_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
          ovr_d   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        therm_d = fixed_code;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request outside IDLE (including DONE) is dropped, never queued.
    if (conv_start && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  assign conv_busy   = (state_q != ST_IDLE);
  assign therm_valid = (state_q == ST_DONE);
  assign therm_out   = therm_q;
  assign err_overrun = ovr_q;

endmodule

// File: tb/tb_ss_thermo_capture.sv
// Scoreboard bench for ss_thermo_capture: stimulus pushes expected codes and
// arrival edges, a monitor pops them whenever therm_valid is presented.
module tb_ss_thermo_capture;

  localparam int SETTLE = 4;
  localparam int SYNC   = 2;

  typedef struct {
    logic [7:0] therm;
    int         vld_edge;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] cmp_in;
  logic       conv_start;
  logic       conv_busy;
  logic [7:0] therm_out;
  logic       therm_valid;
  logic       err_overrun;

  int   cyc     = 0;
  int   n_check = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  ss_thermo_capture #(.SETTLE_CYC(SETTLE), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmp_in      (cmp_in),
    .conv_start  (conv_start),
    .conv_busy   (conv_busy),
    .therm_out   (therm_out),
    .therm_valid (therm_valid),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: majority vote with padded ends, then the length of the unbroken
  // run of ones from the bottom gives the level; code is that many ones above bit 0.
  function automatic logic [7:0] ref_therm(input logic [6:0] c);
    int v[9];
    int level;
    bit run;
    v[0] = 1;
    v[8] = 0;
    for (int k = 0; k < 7; k++) v[k+1] = int'(c[k]);
    level = 0;
    run   = 1;
    for (int k = 0; k < 7; k++) begin
      if (run && (v[k] + v[k+1] + v[k+2] >= 2)) level++;
      else run = 0;
    end
    return 8'(((1 << level) - 1) << 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request; when accepted the expected code and arrival edge are queued.
  // With change=1 the comparator value moves early in SETTLE and the late value counts.
  task automatic run_conv(input logic [6:0] a, input logic [6:0] b, input bit change,
                          input bit accept);
    cmp_in     = a;
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
    if (accept) sb.push_back('{therm: ref_therm(change ? b : a), vld_edge: cyc + SETTLE + 2});
    if (change) begin
      tick();
      cmp_in = b;
    end
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (therm_valid) seen = 1;
      else tick();
    end
    if (!seen) check("valid_timeout", 32'(0), 32'(1));
  endtask

  always @(negedge clk) begin
    if (rst_n && therm_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("therm_out", 32'(therm_out), 32'(e.therm));
        check("valid_latency", 32'(cyc + 1), 32'(e.vld_edge));
      end
    end
  end

  initial begin
    logic [6:0] a;
    logic [6:0] b;
    bit         chg;
    rst_n      = 1'b0;
    cmp_in     = 7'h55;
    conv_start = 1'b0;
    #12;
    check("rst_busy", 32'(conv_busy), 32'(0));
    check("rst_therm", 32'(therm_out), 32'(0));
    check("rst_valid", 32'(therm_valid), 32'(0));
    check("rst_ovr", 32'(err_overrun), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Nominal conversion and encoder view of the code.
    run_conv(7'b0000111, 7'h00, 0, 1);
    check("busy_after_start", 32'(conv_busy), 32'(1));
    wait_valid();
    tick();
    check("code_0000111", 32'(therm_out), 32'(8'b00001110));
    check("encoder_level", 32'($countones(therm_out)), 32'(3));
    check("idle_after_done", 32'(conv_busy), 32'(0));

    // Bubble patterns and extremes.
    run_conv(7'b0001011, 7'h00, 0, 1); wait_valid(); tick();
    check("bubble_0001011", 32'(therm_out), 32'(8'b00001110));
    run_conv(7'b0100111, 7'h00, 0, 1); wait_valid(); tick();
    check("bubble_0100111", 32'(therm_out), 32'(8'b00001110));
    run_conv(7'h00, 7'h00, 0, 1); wait_valid(); tick();
    check("code_zero", 32'(therm_out), 32'(8'h00));
    run_conv(7'h7F, 7'h00, 0, 1); wait_valid(); tick();
    check("code_full", 32'(therm_out), 32'(8'hFE));
    cmp_in = 7'h00;
    repeat (3) tick();
    check("therm_hold", 32'(therm_out), 32'(8'hFE));

    // Overrun two cycles after a start, then clearing on the next accepted start.
    run_conv(7'b0011111, 7'h00, 0, 1);
    tick();
    run_conv(7'b0011111, 7'h00, 0, 0);
    wait_valid();
    check("ovr_set", 32'(err_overrun), 32'(1));
    tick();
    check("ovr_sticky", 32'(err_overrun), 32'(1));
    run_conv(7'b0000001, 7'h00, 0, 1);
    check("ovr_clear", 32'(err_overrun), 32'(0));
    wait_valid();

    // Request seen during DONE is an overrun.
    run_conv(7'b0000001, 7'h00, 0, 0);
    check("ovr_in_done", 32'(err_overrun), 32'(1));
    check("done_not_queued", 32'(conv_busy), 32'(0));

    // Back-to-back: start in the cycle right after the strobe.
    run_conv(7'b0111111, 7'h00, 0, 1);
    wait_valid();
    tick();
    run_conv(7'b0000011, 7'h00, 0, 1);
    check("b2b_no_ovr", 32'(err_overrun), 32'(0));
    check("b2b_busy", 32'(conv_busy), 32'(1));
    wait_valid();
    tick();

    // Reset in SETTLE with overrun pending: everything drops at once, no strobe.
    run_conv(7'h7F, 7'h00, 0, 1);
    run_conv(7'h7F, 7'h00, 0, 0);
    check("pre_rst_ovr", 32'(err_overrun), 32'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(conv_busy), 32'(0));
    check("midrst_therm", 32'(therm_out), 32'(0));
    check("midrst_valid", 32'(therm_valid), 32'(0));
    check("midrst_ovr", 32'(err_overrun), 32'(0));
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    run_conv(7'b0001111, 7'h00, 0, 1);
    wait_valid();
    tick();

    // Randomized conversions, some with the comparators moving during SETTLE.
    for (int i = 0; i < 24; i++) begin
      a   = 7'($urandom);
      b   = 7'($urandom);
      chg = 1'($urandom);
      run_conv(a, b, chg, 1);
      wait_valid();
      tick();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
    end

    repeat (4) tick();
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
